game_ctrl: RTL
==============

Name: game_ctrl

Overview:
Turn sequencer for the code-breaking game. It owns guess entry (cursor and peg colour editing), scores each confirmed guess against the latched secret, and drives the history block: the commit pulse to its select input, the mode line, and the browse pulses. It also tracks the turn count and the win/lose end state. It sits between the button edge-detectors and the history/display blocks.

Parameters:
NUM_COLORS, 6, legal peg colours are 0..NUM_COLORS-1 (range 2..8)
MAX_TURNS, 8, number of guesses before loss (range 1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_up  in  1  one-cycle pulse, already debounced and edge-detected
btn_down  in  1  one-cycle pulse
btn_left  in  1  one-cycle pulse
btn_right  in  1  one-cycle pulse
btn_select  in  1  one-cycle pulse
btn_mode  in  1  one-cycle pulse
secret0..secret3  in  3 each  code to break
guess0..guess3  out  3 each  current guess, connects to history guess0..3
commit  out  1  one-cycle pulse, connects to history btn_select
mode  out  1  0 = guess mode, 1 = history browse; connects to history mode
hist_up, hist_down  out  1  browse pulses, connect to history btn_up/btn_down
cursor  out  2  peg currently being edited
turn  out  4  number of committed guesses
black  out  3  pegs with right colour in right position, last scored guess
white  out  3  pegs with right colour in wrong position, last scored guess
score_valid  out  1  black/white are valid
game_over  out  1  game has ended
win  out  1  game ended with black==4
dup_err  out  1  see Optional Feature

Behaviour:
- All outputs and state are 0 on reset (asynchronous); state = EDIT.
- Only one button action per cycle. Priority: select > mode > up/down > left/right. Lower-priority pulses in the same cycle are dropped.
- EDIT state:
  - left/right move the cursor with wrap (0-left gives 3; 3-right gives 0).
  - up increments guess[cursor], with NUM_COLORS-1 wrapping to 0. down decrements, with 0 wrapping to NUM_COLORS-1.
  - up and down together: no change.
  - select: latch secret0..3 into an internal register, clear score_valid, go to SCORE.
  - mode: mode<=1, remember return state EDIT, go to HIST.
- SCORE state lasts exactly NUM_COLORS cycles, with colour index c = 0..NUM_COLORS-1:
  - On entry, black_acc = count of positions where guess==secret.
  - Each cycle, match_acc += min(count of c in guess, count of c in secret).
  - All buttons are ignored. Guess outputs are frozen.
- COMMIT state lasts 1 cycle:
  - commit=1.
  - black<=black_acc, white<=match_acc-black_acc, score_valid<=1, turn<=turn+1.
  - Next state: if black_acc==4, DONE with win=1. Else if turn+1==MAX_TURNS, DONE with win=0. Else EDIT.
  - Guess and cursor are retained, not cleared.
- Latency: select sampled at edge T. commit and score_valid are high after edge T+NUM_COLORS+1.
- HIST state:
  - hist_up/hist_down are registered copies of btn_up/btn_down (1-cycle delay). Both high together: neither asserted.
  - Guess, cursor and select are ignored.
  - mode: mode<=0, return to the remembered state (EDIT or DONE).
- DONE state:
  - game_over=1. Only mode (enter/leave HIST) is honoured.
  - Only reset starts a new game.
- reset mid-SCORE or mid-COMMIT aborts the turn: no commit pulse, turn stays 0.
- The secret inputs may change during SCORE without effect, because the latched copy is used.
- black+white ≤ 4 always. turn saturates at MAX_TURNS.

Optional Feature:
DUP_CHECK_EN
- Defined: a select in EDIT with any two equal guess pegs is rejected. State stays EDIT, dup_err pulses for 1 cycle, score_valid is unchanged, no commit.
- Undefined: duplicate colours are legal and scored normally. dup_err is tied to 0.

Test Plan:
- From reset, secret 1-2-3-4; edit guess to 1-2-4-3 and select -> commit pulse 7 cycles after the select edge; black=2, white=2, turn=1, score_valid=1, state back to EDIT with guess held.
- Secret 5-5-0-1, guess 5-0-5-5 -> black=1, white=2 (checks min-count duplicate handling; run with DUP_CHECK_EN undefined).
- Guess 1-2-3-4 against secret 1-2-3-4 -> black=4, win=1, game_over=1; further select/up ignored; mode still toggles mode 1/0.
- 8 non-winning guesses -> after the 8th commit, turn=8, game_over=1, win=0.
- Wrap and browse: down at colour 0 gives 5; left at cursor 0 gives 3; mode then btn_down gives mode=1 and hist_down high 1 cycle later, guess unchanged; select in HIST gives no commit.
- Reset asserted 3 cycles into SCORE -> all outputs 0 immediately, no commit. With DUP_CHECK_EN, guess 2-2-0-1 plus select -> dup_err pulse, no commit.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: turn sequencer for the code-breaking game.
// Handles guess entry, scores each confirmed guess against a latched secret
// over NUM_COLORS cycles, drives the history block, and tracks turn/end state.
// Optional feature macro: DUP_CHECK_EN (reject guesses with repeated colours).
module game_ctrl #(
  parameter int NUM_COLORS = 6,
  parameter int MAX_TURNS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  input  logic       btn_mode,
  input  logic [2:0] secret0,
  input  logic [2:0] secret1,
  input  logic [2:0] secret2,
  input  logic [2:0] secret3,
  output logic [2:0] guess0,
  output logic [2:0] guess1,
  output logic [2:0] guess2,
  output logic [2:0] guess3,
  output logic       commit,
  output logic       mode,
  output logic       hist_up,
  output logic       hist_down,
  output logic [1:0] cursor,
  output logic [3:0] turn,
  output logic [2:0] black,
  output logic [2:0] white,
  output logic       score_valid,
  output logic       game_over,
  output logic       win,
  output logic       dup_err
);

`ifdef DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  localparam logic [2:0] COL_MAX  = 3'(NUM_COLORS - 1);
  localparam logic [4:0] TURN_LIM = 5'(MAX_TURNS);
  localparam logic [3:0] TURN_SAT = 4'(MAX_TURNS);

  typedef enum logic [2:0] {
    S_EDIT,
    S_SCORE,
    S_COMMIT,
    S_HIST,
    S_DONE
  } state_t;

  state_t     state;
  state_t     ret_state;
  logic [2:0] peg      [4];
  logic [2:0] secret_q [4];
  logic [2:0] sec_in   [4];
  logic [2:0] col_idx;
  logic [2:0] black_acc;
  logic [2:0] match_acc;

  logic [2:0] black_now;
  logic       dup_found;
  logic [2:0] g_cnt;
  logic [2:0] s_cnt;
  logic [2:0] color_match;
  logic [2:0] peg_inc;
  logic [2:0] peg_dec;

  assign guess0 = peg[0];
  assign guess1 = peg[1];
  assign guess2 = peg[2];
  assign guess3 = peg[3];

  // Scoring helpers: exact matches, duplicate detection, per-colour min count, peg edit values
  always_comb begin
    sec_in[0]   = secret0;
    sec_in[1]   = secret1;
    sec_in[2]   = secret2;
    sec_in[3]   = secret3;
    black_now   = '0;
    dup_found   = 1'b0;
    g_cnt       = '0;
    s_cnt       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (peg[i] == sec_in[i]) black_now = black_now + 3'd1;
      if (peg[i] == col_idx) g_cnt = g_cnt + 3'd1;
      if (secret_q[i] == col_idx) s_cnt = s_cnt + 3'd1;
      for (int unsigned j = i + 1; j < 4; j++) begin
        if (peg[i] == peg[j]) dup_found = 1'b1;
      end
    end
    color_match = (g_cnt < s_cnt) ? g_cnt : s_cnt;
    peg_inc     = (peg[cursor] == COL_MAX) ? '0 : peg[cursor] + 3'd1;
    peg_dec     = (peg[cursor] == '0) ? COL_MAX : peg[cursor] - 3'd1;
  end

  // Turn sequencer: state, guess editing, scoring accumulation and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_EDIT;
      ret_state   <= S_EDIT;
      for (int unsigned i = 0; i < 4; i++) begin
        peg[i]      <= '0;
        secret_q[i] <= '0;
      end
      col_idx     <= '0;
      black_acc   <= '0;
      match_acc   <= '0;
      commit      <= 1'b0;
      mode        <= 1'b0;
      hist_up     <= 1'b0;
      hist_down   <= 1'b0;
      cursor      <= '0;
      turn        <= '0;
      black       <= '0;
      white       <= '0;
      score_valid <= 1'b0;
      game_over   <= 1'b0;
      win         <= 1'b0;
      dup_err     <= 1'b0;
    end else begin
      commit    <= 1'b0;
      hist_up   <= 1'b0;
      hist_down <= 1'b0;
      dup_err   <= 1'b0;
      case (state)
        S_EDIT: begin
          if (btn_select) begin
            if (DUP_EN && dup_found) begin
              dup_err <= 1'b1;
            end else begin
              for (int unsigned i = 0; i < 4; i++) secret_q[i] <= sec_in[i];
              black_acc   <= black_now;
              match_acc   <= '0;
              col_idx     <= '0;
              score_valid <= 1'b0;
              state       <= S_SCORE;
            end
          end else if (btn_mode) begin
            mode      <= 1'b1;
            ret_state <= S_EDIT;
            state     <= S_HIST;
          end else if (btn_up || btn_down) begin
            // up+down together consumes the action slot but edits nothing
            if (btn_up && !btn_down) peg[cursor] <= peg_inc;
            else if (btn_down && !btn_up) peg[cursor] <= peg_dec;
          end else if (btn_left) begin
            cursor <= cursor - 2'd1;
          end else if (btn_right) begin
            cursor <= cursor + 2'd1;
          end
        end

        S_SCORE: begin
          match_acc <= match_acc + color_match;
          if (col_idx == COL_MAX) state <= S_COMMIT;
          else col_idx <= col_idx + 3'd1;
        end

        S_COMMIT: begin
          commit      <= 1'b1;
          black       <= black_acc;
          white       <= match_acc - black_acc;
          score_valid <= 1'b1;
          if (turn != TURN_SAT) turn <= turn + 4'd1;
          if (black_acc == 3'd4) begin
            win       <= 1'b1;
            game_over <= 1'b1;
            state     <= S_DONE;
          end else if (({1'b0, turn} + 5'd1) == TURN_LIM) begin
            game_over <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_EDIT;
          end
        end

        S_HIST: begin
          if (btn_mode) begin
            mode  <= 1'b0;
            state <= ret_state;
          end else begin
            hist_up   <= btn_up & ~btn_down;
            hist_down <= btn_down & ~btn_up;
          end
        end

        S_DONE: begin
          if (btn_mode) begin
            mode      <= 1'b1;
            ret_state <= S_DONE;
            state     <= S_HIST;
          end
        end

        default: state <= S_EDIT;
      endcase
    end
  end

endmodule
